// File: rtl/smac_ctrl_pkg.sv
// Shared configuration types, field widths and legality check for the SMAC control-counter bank.
// Precision and size limits are package constants so every user of cfg_t agrees on field widths.
package smac_ctrl_pkg;

  localparam int PW_MAX = 8;
  localparam int PA_MAX = 8;
  localparam int MNO    = 288;
  localparam int MNV    = 224 * 224;
  localparam int MWB    = 16;

  localparam int W_WB  = $clog2(PW_MAX + 1);
  localparam int W_AB  = $clog2(PA_MAX + 1);
  localparam int W_NF  = $clog2(MNO + 1);
  localparam int W_QL  = $clog2(PA_MAX * PW_MAX + 1);
  localparam int W_NWB = $clog2(MWB + 1);
  localparam int W_NV  = $clog2(MNV + 1);

  typedef struct packed {
    logic [W_WB-1:0]  wbits;
    logic [W_AB-1:0]  abits;
    logic [W_NF-1:0]  nfil;
    logic [W_QL-1:0]  qlen;
    logic [W_NWB-1:0] nwb;
    logic [W_NV-1:0]  nvol;
  } cfg_t;

  localparam cfg_t CFG_MAX = '{
    wbits: W_WB'(PW_MAX),
    abits: W_AB'(PA_MAX),
    nfil:  W_NF'(MNO),
    qlen:  W_QL'(PA_MAX * PW_MAX),
    nwb:   W_NWB'(MWB),
    nvol:  W_NV'(MNV)
  };

  // qlen may legally be zero (no quant window); every other field must be 1..max.
  function automatic logic cfg_ok(input cfg_t c);
    return (c.wbits != '0) && (int'(c.wbits) <= PW_MAX) &&
           (c.abits != '0) && (int'(c.abits) <= PA_MAX) &&
           (c.nfil  != '0) && (int'(c.nfil)  <= MNO)    &&
           (int'(c.qlen) <= PA_MAX * PW_MAX)            &&
           (c.nwb   != '0) && (int'(c.nwb)   <= MWB)    &&
           (c.nvol  != '0) && (int'(c.nvol)  <= MNV);
  endfunction

endpackage

// File: rtl/pos_edge_det.sv
// Rising-edge detector; pulse is high in the first cycle d is seen high.
module pos_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/smac_cnt_wrap.sv
// Programmable terminal-count counter: counts 0..max, then wraps to 0 (or holds when HOLD=1).
module smac_cnt_wrap #(
  parameter int W    = 4,
  parameter bit HOLD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) cnt <= HOLD ? cnt : '0;
      else    cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/smac_ctrl_cnt_seq.sv
// SMAC control-counter bank: weight-group pointer, bit-serial counters, filter/quant/write-back/volume
// progress and status pulses toward the layer FSM, with a runtime-loadable shadow configuration.
module smac_ctrl_cnt_seq
  import smac_ctrl_pkg::*;
#(
  parameter int NGRP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_load,
  input  logic             clr_start,
  input  logic             clr_finish,
  input  logic             clr_vol,
  input  logic             wei_load,
  input  logic             w_en_w,
  input  logic             w_and_s_ac1,
  input  logic             valid_ac3,
  input  logic             act_wb,
  input  logic             vol_inc,
  input  logic             cont_mode,
  input  logic [W_WB-1:0]  cfg_wbits,
  input  logic [W_AB-1:0]  cfg_abits,
  input  logic [W_NF-1:0]  cfg_nfil,
  input  logic [W_QL-1:0]  cfg_qlen,
  input  logic [W_NWB-1:0] cfg_nwb,
  input  logic [W_NV-1:0]  cfg_nvol,
  output logic [NGRP-1:0]  grp_we,
  output logic             grp_last,
  output logic             bit_1,
  output logic             bit_m,
  output logic             term_ac1,
  output logic             last_fil,
  output logic             s_en_ac3,
  output logic             done_quant,
  output logic             wb_done,
  output logic             op_done,
  output logic             update,
  output logic             cfg_err
);

  // All control inputs are single-cycle strobes sampled on the rising edge; there is no back-pressure.
  cfg_t             cfg_q, cfg_in;
  logic [NGRP-1:0]  ptr;
  logic [W_WB-1:0]  wbit_cnt;
  logic [W_AB-1:0]  abit_cnt;
  logic [W_NF-1:0]  fil_cnt;
  logic [W_NWB-1:0] wb_cnt;
  logic [W_NV-1:0]  vol_cnt;
  logic [W_QL-1:0]  qcnt;
  logic             wb_tc, vol_tc, vol_en;
  logic             done_int, q_start, upd_cond, busy;

  assign cfg_in = '{wbits: cfg_wbits, abits: cfg_abits, nfil: cfg_nfil,
                    qlen: cfg_qlen, nwb: cfg_nwb, nvol: cfg_nvol};

  assign busy = ~ptr[0] | (|wbit_cnt) | (|abit_cnt) | (|fil_cnt) |
                (|wb_cnt) | (|vol_cnt) | s_en_ac3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= CFG_MAX;
      cfg_err <= 1'b0;
    end else begin
      if (cnt_load && !busy && cfg_ok(cfg_in)) cfg_q <= cfg_in;
      if (clr_finish)                                 cfg_err <= 1'b0;
      else if (cnt_load && (busy || !cfg_ok(cfg_in))) cfg_err <= 1'b1;
    end
  end

  // One-hot group pointer; the OR with the right shift closes the rotation ring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr <= NGRP'(1);
    else if (clr_start) ptr <= NGRP'(1);
    else if (wei_load)  ptr <= (ptr << 1) | (ptr >> (NGRP - 1));
  end

  assign grp_we   = ptr & {NGRP{wei_load}};
  assign grp_last = ptr[NGRP-1];

  smac_cnt_wrap #(.W(W_WB), .HOLD(1'b0)) u_wbit (
    .clk(clk), .rst_n(rst_n), .clr(clr_start), .en(w_en_w),
    .max(cfg_q.wbits - W_WB'(1)), .cnt(wbit_cnt), .tc(bit_m)
  );

  smac_cnt_wrap #(.W(W_AB), .HOLD(1'b0)) u_abit (
    .clk(clk), .rst_n(rst_n), .clr(clr_start), .en(w_and_s_ac1),
    .max(cfg_q.abits - W_AB'(1)), .cnt(abit_cnt), .tc(term_ac1)
  );

  smac_cnt_wrap #(.W(W_NF), .HOLD(1'b1)) u_fil (
    .clk(clk), .rst_n(rst_n), .clr(clr_finish), .en(valid_ac3),
    .max(cfg_q.nfil - W_NF'(1)), .cnt(fil_cnt), .tc(last_fil)
  );

  smac_cnt_wrap #(.W(W_NWB), .HOLD(1'b0)) u_wb (
    .clk(clk), .rst_n(rst_n), .clr(clr_finish), .en(act_wb),
    .max(cfg_q.nwb - W_NWB'(1)), .cnt(wb_cnt), .tc(wb_tc)
  );

  // A finished non-continuous layer ignores further volumes until clr_vol.
  assign vol_en = vol_inc & ~(op_done & ~cont_mode);

  smac_cnt_wrap #(.W(W_NV), .HOLD(1'b0)) u_vol (
    .clk(clk), .rst_n(rst_n), .clr(clr_vol), .en(vol_en),
    .max(cfg_q.nvol - W_NV'(1)), .cnt(vol_cnt), .tc(vol_tc)
  );

  assign bit_1 = (wbit_cnt == W_WB'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      done_int <= 1'b0;
    else if (clr_finish)             done_int <= 1'b0;
    else if (valid_ac3 && last_fil)  done_int <= 1'b1;
  end

  pos_edge_det u_qst (.clk(clk), .rst_n(rst_n), .d(done_int), .pulse(q_start));

  // qcnt holds the remaining quant-window cycles; the window is simply qcnt != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt       <= '0;
      done_quant <= 1'b0;
    end else if (clr_finish) begin
      qcnt       <= '0;
      done_quant <= 1'b0;
    end else if (q_start) begin
      qcnt <= cfg_q.qlen;
      if (cfg_q.qlen == '0) done_quant <= 1'b1;
    end else if (qcnt != '0) begin
      qcnt <= qcnt - W_QL'(1);
      if (qcnt == W_QL'(1)) done_quant <= 1'b1;
    end
  end

  assign s_en_ac3 = (qcnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wb_done <= 1'b0;
    else if (clr_finish) wb_done <= 1'b0;
    else                 wb_done <= act_wb & wb_tc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                op_done <= 1'b0;
    else if (clr_vol)          op_done <= 1'b0;
    else if (vol_en && vol_tc) op_done <= 1'b1;
    else if (cont_mode)        op_done <= 1'b0;
  end

  assign upd_cond = bit_m & grp_last & ~last_fil;

  pos_edge_det u_upd (.clk(clk), .rst_n(rst_n), .d(upd_cond), .pulse(update));

endmodule

// File: tb/tb_smac_ctrl_cnt_seq.sv
// Directed bench for smac_ctrl_cnt_seq: count-level reference model checked every cycle plus literal checkpoints.
module tb_smac_ctrl_cnt_seq;
  import smac_ctrl_pkg::*;

  localparam int NGRP = 8;
  localparam logic [9:0] S_WEI = 10'd1,   S_WEN = 10'd2,   S_ACT = 10'd4,   S_VAL = 10'd8;
  localparam logic [9:0] S_WB  = 10'd16,  S_VOL = 10'd32,  S_CS  = 10'd64,  S_CF  = 10'd128;
  localparam logic [9:0] S_CV  = 10'd256, S_LD  = 10'd512;

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst_n;
  logic cnt_load, clr_start, clr_finish, clr_vol, wei_load, w_en_w, w_and_s_ac1;
  logic valid_ac3, act_wb, vol_inc, cont_mode;
  logic [W_WB-1:0]  cfg_wbits;
  logic [W_AB-1:0]  cfg_abits;
  logic [W_NF-1:0]  cfg_nfil;
  logic [W_QL-1:0]  cfg_qlen;
  logic [W_NWB-1:0] cfg_nwb;
  logic [W_NV-1:0]  cfg_nvol;
  logic [NGRP-1:0]  grp_we;
  logic grp_last, bit_1, bit_m, term_ac1, last_fil, s_en_ac3, done_quant;
  logic wb_done, op_done, update, cfg_err;

  smac_ctrl_cnt_seq #(.NGRP(NGRP)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_load(cnt_load), .clr_start(clr_start),
    .clr_finish(clr_finish), .clr_vol(clr_vol), .wei_load(wei_load), .w_en_w(w_en_w),
    .w_and_s_ac1(w_and_s_ac1), .valid_ac3(valid_ac3), .act_wb(act_wb), .vol_inc(vol_inc),
    .cont_mode(cont_mode), .cfg_wbits(cfg_wbits), .cfg_abits(cfg_abits), .cfg_nfil(cfg_nfil),
    .cfg_qlen(cfg_qlen), .cfg_nwb(cfg_nwb), .cfg_nvol(cfg_nvol), .grp_we(grp_we),
    .grp_last(grp_last), .bit_1(bit_1), .bit_m(bit_m), .term_ac1(term_ac1),
    .last_fil(last_fil), .s_en_ac3(s_en_ac3), .done_quant(done_quant), .wb_done(wb_done),
    .op_done(op_done), .update(update), .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (counts and cycle stamps) ----------------
  int m_wbits, m_abits, m_nfil, m_qlen, m_nwb, m_nvol;
  int m_g, m_w, m_a, m_fil, m_beats, m_vol, m_rise, m_qwin, cyc;
  bit m_err, m_done, m_wbp, m_od, m_prev_c;

  task automatic m_reset();
    m_wbits = PW_MAX; m_abits = PA_MAX; m_nfil = MNO; m_qlen = PA_MAX * PW_MAX;
    m_nwb = MWB; m_nvol = MNV;
    m_g = 0; m_w = 0; m_a = 0; m_fil = 0; m_beats = 0; m_vol = 0;
    m_rise = -1; m_qwin = 0; cyc = 0;
    m_err = 0; m_done = 0; m_wbp = 0; m_od = 0; m_prev_c = 0;
  endtask

  function automatic bit m_sen();
    return (m_rise >= 0) && (cyc > m_rise) && (cyc <= m_rise + m_qwin);
  endfunction

  function automatic bit m_dq();
    return (m_rise >= 0) && (cyc > m_rise + m_qwin);
  endfunction

  function automatic bit m_cond();
    return (m_w == m_wbits - 1) && (m_g == NGRP - 1) && (m_fil != m_nfil - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit busy, legal, hit;
    if (!rst_n) begin
      m_reset();
    end else begin
      busy = (m_g != 0) || (m_w != 0) || (m_a != 0) || (m_fil != 0) ||
             (m_beats != 0) || (m_vol != 0) || m_sen();
      legal = (cfg_wbits >= 1) && (cfg_wbits <= PW_MAX) && (cfg_abits >= 1) &&
              (cfg_abits <= PA_MAX) && (cfg_nfil >= 1) && (cfg_nfil <= MNO) &&
              (cfg_qlen <= PA_MAX * PW_MAX) && (cfg_nwb >= 1) && (cfg_nwb <= MWB) &&
              (cfg_nvol >= 1) && (cfg_nvol <= MNV);
      m_prev_c = m_cond();
      if (clr_start) m_g = 0; else if (wei_load) m_g = (m_g + 1) % NGRP;
      if (clr_start) m_w = 0; else if (w_en_w) m_w = (m_w + 1) % m_wbits;
      if (clr_start) m_a = 0; else if (w_and_s_ac1) m_a = (m_a + 1) % m_abits;
      if (clr_finish) begin
        m_fil = 0; m_done = 0; m_rise = -1;
      end else if (valid_ac3) begin
        if (m_fil == m_nfil - 1) begin
          if (!m_done) begin m_done = 1; m_rise = cyc + 1; m_qwin = m_qlen; end
        end else m_fil++;
      end
      m_wbp = 0;
      if (clr_finish) m_beats = 0;
      else if (act_wb) begin
        m_beats++;
        if (m_beats == m_nwb) begin m_beats = 0; m_wbp = 1; end
      end
      hit = 0;
      if (clr_vol) begin
        m_vol = 0; m_od = 0;
      end else begin
        if (vol_inc && !(m_od && !cont_mode)) begin
          m_vol++;
          if (m_vol == m_nvol) begin m_vol = 0; hit = 1; end
        end
        if (hit) m_od = 1; else if (cont_mode) m_od = 0;
      end
      if (clr_finish) m_err = 0;
      else if (cnt_load && (busy || !legal)) m_err = 1;
      if (cnt_load && !busy && legal) begin
        m_wbits = cfg_wbits; m_abits = cfg_abits; m_nfil = cfg_nfil;
        m_qlen = cfg_qlen; m_nwb = cfg_nwb; m_nvol = cfg_nvol;
      end
      cyc++;
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    chk("mdl_grp_we",   grp_we,     wei_load ? (32'd1 << m_g) : 32'd0);
    chk("mdl_grp_last", grp_last,   m_g == NGRP - 1);
    chk("mdl_bit_1",    bit_1,      m_w == 1);
    chk("mdl_bit_m",    bit_m,      m_w == m_wbits - 1);
    chk("mdl_term_ac1", term_ac1,   m_a == m_abits - 1);
    chk("mdl_last_fil", last_fil,   m_fil == m_nfil - 1);
    chk("mdl_s_en_ac3", s_en_ac3,   m_sen());
    chk("mdl_done_q",   done_quant, m_dq());
    chk("mdl_wb_done",  wb_done,    m_wbp);
    chk("mdl_op_done",  op_done,    m_od);
    chk("mdl_update",   update,     m_cond() && !m_prev_c);
    chk("mdl_cfg_err",  cfg_err,    m_err);
  end

  // ---------------- driver ----------------
  logic [NGRP-1:0] snap_we;
  logic            snap_last;
  logic [7:0]      we_tab [10];
  int sen_n, first_sen, first_dq;

  // Called at posedge+1: drives strobes for one cycle, snapshots comb outputs mid-cycle.
  task automatic step(input logic [9:0] s);
    {cnt_load, clr_vol, clr_finish, clr_start, vol_inc, act_wb,
     valid_ac3, w_and_s_ac1, w_en_w, wei_load} = s;
    #3;
    snap_we   = grp_we;
    snap_last = grp_last;
    @(posedge clk);
    #1;
    {cnt_load, clr_vol, clr_finish, clr_start, vol_inc, act_wb,
     valid_ac3, w_and_s_ac1, w_en_w, wei_load} = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    we_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    m_reset();
    rst_n = 1'b0;
    {cnt_load, clr_vol, clr_finish, clr_start, vol_inc, act_wb,
     valid_ac3, w_and_s_ac1, w_en_w, wei_load} = '0;
    cont_mode = 1'b0;
    cfg_wbits = 4; cfg_abits = 3; cfg_nfil = 3; cfg_qlen = 5; cfg_nwb = 3; cfg_nvol = 4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grp_we", grp_we, 0);
    chk("rst_grp_last", grp_last, 0);
    chk("rst_bit_m", bit_m, 0);
    chk("rst_s_en", s_en_ac3, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    step(0);

    step(S_LD);
    chk("cfg_load_ok", cfg_err, 0);

    for (int i = 0; i < 10; i++) begin
      step(S_WEI);
      chk("grp_we_seq", snap_we, we_tab[i]);
      chk("grp_last_seq", snap_last, i == 7);
    end
    step(S_CS);

    repeat (7) step(S_WEI);
    chk("grp_last_at7", grp_last, 1);
    for (int i = 0; i < 9; i++) begin
      step(S_WEN);
      chk("bit_m_seq", bit_m, (i == 2) || (i == 6));
      chk("bit_1_seq", bit_1, (i % 4) == 0);
      chk("update_seq", update, (i == 2) || (i == 6));
    end
    step(S_CS);

    for (int i = 0; i < 3; i++) begin
      step(S_ACT);
      chk("term_ac1_seq", term_ac1, i == 1);
    end

    step(S_WEN);
    step(S_WEN);
    cfg_wbits = 0; cfg_nvol = 2;
    step(S_LD);
    chk("busy_bad_load_err", cfg_err, 1);
    cfg_wbits = 4; cfg_nvol = 4;
    step(S_WEN);
    chk("cfg_kept_bit_m", bit_m, 1);
    step(S_CF);
    chk("err_cleared", cfg_err, 0);
    cfg_wbits = 8;
    step(S_LD);
    chk("busy_legal_load_err", cfg_err, 1);
    cfg_wbits = 4;
    step(S_WEN);
    step(S_WEN);
    chk("cfg_kept_bit_1", bit_1, 1);
    step(S_CS | S_CF);
    chk("err_cleared2", cfg_err, 0);
    cfg_nwb = 17;
    step(S_LD);
    chk("idle_over_max_err", cfg_err, 1);
    cfg_nwb = 3;
    step(S_CF);

    for (int i = 0; i < 3; i++) begin
      step(S_VAL);
      chk("last_fil_seq", last_fil, i >= 1);
    end
    sen_n = 0; first_sen = -1; first_dq = -1;
    for (int t = 0; t < 10; t++) begin
      step(0);
      if (s_en_ac3) begin
        sen_n++;
        if (first_sen < 0) first_sen = t;
      end
      if (done_quant && first_dq < 0) first_dq = t;
    end
    chk("quant_window_len", sen_n, 5);
    chk("quant_window_start", first_sen, 0);
    chk("done_quant_after_window", first_dq, 5);
    chk("done_quant_sticky", done_quant, 1);
    step(S_CF);
    chk("done_quant_cleared", done_quant, 0);
    chk("fil_cleared", last_fil, 0);

    for (int i = 0; i < 7; i++) begin
      step(S_WB);
      chk("wb_done_seq", wb_done, (i == 2) || (i == 5));
    end
    step(S_CF);

    cont_mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(S_VOL);
      chk("op_done_cont", op_done, (i == 3) || (i == 7));
    end
    step(S_CV);
    cont_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(S_VOL);
      chk("op_done_sticky", op_done, i >= 3);
    end
    step(S_CV);
    chk("op_done_cleared", op_done, 0);

    repeat (7) step(S_WEI | S_WEN);
    for (int i = 0; i < 3; i++) step(S_VAL);
    step(0);
    step(0);
    chk("win_active", s_en_ac3, 1);
    chk("pre_rst_grp_last", grp_last, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_en", s_en_ac3, 0);
    chk("async_rst_done_q", done_quant, 0);
    chk("async_rst_grp_last", grp_last, 0);
    chk("async_rst_bit_m", bit_m, 0);
    chk("async_rst_last_fil", last_fil, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(S_WEN);
    chk("post_rst_bit_1", bit_1, 1);
    step(S_WEN);
    step(S_WEN);
    chk("post_rst_max_wbits", bit_m, 0);
    step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
